// File: rtl/cplx_alu_seq.sv
// Complex-number sequencer: splits one complex op into scalar ALU ops,
// issues them one per cycle and recombines the registered ALU results.
module cplx_alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  cop,
    input  logic [4:0]  a_re,
    input  logic [4:0]  a_im,
    input  logic [4:0]  b_re,
    input  logic [4:0]  b_im,
    output logic [4:0]  alu_op1,
    output logic [4:0]  alu_op2,
    output logic [1:0]  alu_opcode,
    input  logic [9:0]  alu_out,
    input  logic        alu_valid,
    output logic [11:0] res_re,
    output logic [11:0] res_im,
    output logic        res_valid,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  cop_q, cop_d;
    logic [4:0]  ar_q, ar_d, ai_q, ai_d;
    logic [4:0]  br_q, br_d, bi_q, bi_d;
    logic [9:0]  r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
    logic [4:0]  op1_q, op1_d, op2_q, op2_d;
    logic [1:0]  opc_q, opc_d;
    logic [11:0] re_q, re_d, im_q, im_d;
    logic        rv_q, rv_d;
    logic        err_q, err_d;

    logic [2:0]  n_ops;
    logic        capture;
    logic        last;

    always_comb begin
        n_ops   = (cop_q == 2'b11) ? 3'd4 : 3'd2;
        // cnt_q counts cycles since accept; results arrive two cycles after issue
        capture = (state_q != S_IDLE) && (cnt_q >= 3'd2);
        last    = capture && (cnt_q == n_ops + 3'd1);

        state_d = state_q;
        cnt_d   = cnt_q;
        cop_d   = cop_q;
        ar_d    = ar_q;
        ai_d    = ai_q;
        br_d    = br_q;
        bi_d    = bi_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        opc_d   = 2'b00;
        re_d    = re_q;
        im_d    = im_q;
        rv_d    = 1'b0;
        err_d   = err_q | (capture ^ alu_valid);

        if (capture) begin
            case (cnt_q)
                3'd2:    r0_d = alu_out;
                3'd3:    r1_d = alu_out;
                3'd4:    r2_d = alu_out;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cop_d = cop;
                    ar_d  = a_re;
                    ai_d  = a_im;
                    br_d  = b_re;
                    bi_d  = b_im;
                    if (cop == 2'b00) begin
                        re_d = 12'd0;
                        im_d = 12'd0;
                        rv_d = 1'b1;
                    end else begin
                        op1_d   = a_re;
                        op2_d   = b_re;
                        opc_d   = cop;
                        cnt_d   = 3'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                opc_d = cop_q;
                cnt_d = cnt_q + 3'd1;
                case (cnt_q[1:0])
                    2'd1: begin
                        op1_d = ai_q;
                        op2_d = bi_q;
                    end
                    2'd2: begin
                        op1_d = ar_q;
                        op2_d = bi_q;
                    end
                    default: begin
                        op1_d = ai_q;
                        op2_d = br_q;
                    end
                endcase
                if (cnt_q == n_ops - 3'd1)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 3'd1;
                if (last) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                    rv_d    = 1'b1;
                    case (cop_q)
                        2'b01: begin
                            re_d = {{2{r0_q[9]}}, r0_q};
                            im_d = {{2{alu_out[9]}}, alu_out};
                        end
                        2'b11: begin
                            re_d = {2'b00, r0_q} - {2'b00, r1_q};
                            im_d = {2'b00, r2_q} + {2'b00, alu_out};
                        end
                        default: begin
                            re_d = {2'b00, r0_q};
                            im_d = {2'b00, alu_out};
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            cop_q   <= 2'b00;
            ar_q    <= 5'd0;
            ai_q    <= 5'd0;
            br_q    <= 5'd0;
            bi_q    <= 5'd0;
            r0_q    <= 10'd0;
            r1_q    <= 10'd0;
            r2_q    <= 10'd0;
            op1_q   <= 5'd0;
            op2_q   <= 5'd0;
            opc_q   <= 2'b00;
            re_q    <= 12'd0;
            im_q    <= 12'd0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cop_q   <= cop_d;
            ar_q    <= ar_d;
            ai_q    <= ai_d;
            br_q    <= br_d;
            bi_q    <= bi_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            opc_q   <= opc_d;
            re_q    <= re_d;
            im_q    <= im_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign alu_opcode = opc_q;
    assign res_re     = re_q;
    assign res_im     = im_q;
    assign res_valid  = rv_q;
    assign err        = err_q;

endmodule

// File: doc/cplx_alu_seq.md
# cplx_alu_seq

Complex-number sequencer that sits directly upstream of the scalar ALU: accepts one complex operation (two 5-bit-per-component operands), breaks it into scalar ALU ops, issues them one per cycle, collects the registered ALU results and combines them into a 12-bit signed complex result. It drives the ALU's op1/op2/opcode and consumes its out/valid.

## Interface
- No parameters. Widths are fixed: 5-bit components, 10-bit ALU result, 12-bit signed result.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request (high in IDLE).
- cop  in  2  00 = nop, 01 = complex sub, 10 = complex add, 11 = complex mul.
- a_re, a_im, b_re, b_im  in  5 each  unsigned operand components.
- alu_op1, alu_op2  out  5 each  registered operands to the ALU.
- alu_opcode  out  2  registered ALU opcode; 00 when not issuing.
- alu_out  in  10  ALU result.
- alu_valid  in  1  ALU result valid.
- res_re, res_im  out  12 each  two's-complement result.
- res_valid  out  1  one-cycle pulse; res_* held until the next result.
- err  out  1  sticky protocol error.

## Operation
- States:
  - IDLE: in_ready=1. Accept on in_valid&in_ready; latch operands and cop.
  - ISSUE: drives N ops, one per cycle.
  - DRAIN: waits for the remaining results.
  - IDLE is re-entered on the same edge that sets res_valid.
- Op lists (op1, op2, opcode):
  - add (N=2): (a_re, b_re, 10), (a_im, b_im, 10).
  - sub (N=2): (a_re, b_re, 01), (a_im, b_im, 01).
  - mul (N=4): (a_re, b_re, 11)=ac, (a_im, b_im, 11)=bd, (a_re, b_im, 11)=ad, (a_im, b_re, 11)=bc.
- Width rules:
  - sub results are taken as 10-bit signed and sign-extended to 12 bits.
  - add and mul results are zero-extended to 12 bits.
  - add/sub: res_re = r0, res_im = r1.
  - mul: res_re = ac − bd, res_im = ad + bc, computed in 12-bit signed. Range −961..1922, so no overflow.
- cop=00: no ALU traffic. res=0, res_valid pulses in cycle 1, and the block stays in IDLE.
- err is set, and held until reset, in either case:
  - alu_valid=0 at an expected capture edge. alu_out is still captured, and the sequence completes normally.
  - alu_valid=1 at an edge where no capture is expected.
- Reset, including mid-operation:
  - All outputs go to 0 (in_ready=1 once in IDLE; alu_opcode=00; res_*=0; res_valid=0; err=0).
  - State goes to IDLE and in-flight results are discarded.

## Timing
- Cycle 0 is the accept cycle (in_valid&in_ready high).
- Issue:
  - Op k is loaded into alu_* at the end of cycle k and presented during cycle k+1.
  - alu_opcode returns to 00 from cycle N+1.
- Capture:
  - The ALU result for op k is expected during cycle k+2 with alu_valid=1.
  - It is captured at the end of cycle k+2.
- Result:
  - res_* and res_valid are registered from the final capture, so res_valid is high in cycle N+2.
  - add/sub: res_valid in cycle 4. mul: res_valid in cycle 6.
- Back-to-back: in_ready=1 during the res_valid cycle, so a new request may be accepted there.
- Throughput: one op per N+2 cycles.
- in_ready=0 from cycle 1 through cycle N+1.
- A request presented while in_ready=0 is ignored, not queued.

## Test plan
- Add, a=(3,4), b=(5,6) → alu_opcode 10,10 in cycles 1–2; res=(8,10) with res_valid in cycle 4; err=0.
- Sub, a=(2,9), b=(7,1) → res_re=12'hFFB (−5), res_im=8, res_valid in cycle 4.
- Mul, a=(3,2), b=(1,4) → ALU ops (3,1), (2,4), (3,4), (2,1), all opcode 11; res=(−5,14) in cycle 6.
- Mul, a=(31,31), b=(31,31) → res=(0,1922).
- Back-to-back: add accepted in cycle 0, mul accepted in cycle 4 → in_ready=0 in cycles 1–3 and 5–9; results pulse in cycles 4 and 10. A request held while in_ready=0 is not taken early.
- Reset asserted in cycle 3 of a mul → outputs zero immediately, alu_opcode=00, in_ready=1 after release; a following add a=(1,1), b=(1,1) gives (2,2) with err=0.
- Error: ALU model drives alu_valid=0 during an add → err=1 from cycle 3, sticky; result still pulses in cycle 4.
- Error: alu_valid=1 while IDLE → err=1.
